// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder_if
//  Brief    : Request/response handshake between a CPU data port and the
//             data_mem_responder. The shared 32-bit tristate data bus is not
//             carried here; it is a direct inout port of the responder so the
//             resolving net lives in the enclosing scope.
//  Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    logic        req;    // request strobe from CPU
    logic        we;     // 1 = write, 0 = read
    logic [3:0]  be;     // byte enables, bit i covers data[8i+7:8i]
    logic [31:0] addr;   // byte address, bits [1:0] ignored
    logic        ready;  // one-cycle completion pulse
    logic        err;    // out-of-range flag, valid with ready

    modport slave (
        input  req,
        input  we,
        input  be,
        input  addr,
        output ready,
        output err
    );

    modport master (
        output req,
        output we,
        output be,
        output addr,
        input  ready,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Single-port 32-bit data memory that answers CPU requests after a
//             fixed number of wait states. Byte-enabled writes commit on the
//             response edge; reads drive the shared bus only in the response
//             cycle and leave it high-Z otherwise.
//  Options  : define DATA_MEM_BOUNDS_CHECK_EN to flag (err) and suppress
//             accesses whose address lies beyond the array; without it the
//             upper address bits are ignored and the address wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  wire logic            clock_in,
    input  wire logic            reset_in,
    data_mem_responder_if.slave  data_mem,
    inout  wire logic [31:0]     data_mem_data_inout
);

    localparam int         WORDS     = 2 ** DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              count;
    logic                    accept;
    logic                    cap_we;
    logic [3:0]              cap_be;
    logic [DEPTH_LOG2-1:0]   cap_index;
    logic [31:0]             cap_data;
    logic                    out_of_range;
    logic                    ready;
    logic                    err;
    logic                    drive_read;
    logic [31:0]             read_word;

    // Memory contents are deliberately never reset or initialised.
    logic [31:0]             mem [WORDS];

    // A request is only taken from IDLE; WAIT and RESP ignore the inputs.
    assign accept = (state == IDLE) && data_mem.req;

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    logic cap_oob;
    wire  unused_addr_bits = &{1'b0, data_mem.addr[1:0]};

    // Range verdict is taken at accept so later address changes cannot affect it.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            cap_oob <= 1'b0;
        end else if (accept) begin
            cap_oob <= |data_mem.addr[31:DEPTH_LOG2+2];
        end
    end

    assign out_of_range = cap_oob;
`else
    // Upper bits are dropped, so the address simply wraps modulo the depth.
    wire unused_addr_bits = &{1'b0, data_mem.addr[31:DEPTH_LOG2+2], data_mem.addr[1:0]};

    assign out_of_range = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and response outputs; only RESP produces any visible output.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        err        = 1'b0;
        drive_read = 1'b0;
        case (state)
            IDLE: begin
                if (data_mem.req) begin
                    state_next = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                ready      = 1'b1;
                err        = out_of_range;
                drive_read = !cap_we;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Wait-state counter: loaded on accept, counts down to zero while in WAIT.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            count <= 4'd0;
        end else if (accept) begin
            count <= WAIT_LOAD;
        end else if ((state == WAIT) && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    // Request capture; write data is only latched for writes.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            cap_we    <= 1'b0;
            cap_be    <= 4'd0;
            cap_index <= '0;
            cap_data  <= 32'd0;
        end else if (accept) begin
            cap_we    <= data_mem.we;
            cap_be    <= data_mem.be;
            cap_index <= data_mem.addr[DEPTH_LOG2+1:2];
            if (data_mem.we) begin
                cap_data <= data_mem_data_inout;
            end
        end
    end

    // Byte-masked write commit on the RESP edge. A reset forces the state out
    // of RESP immediately, so an aborted transaction never reaches this edge.
    always_ff @(posedge clock_in) begin
        if ((state == RESP) && cap_we && !out_of_range) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) begin
                    mem[cap_index][8*i +: 8] <= cap_data[8*i +: 8];
                end
            end
        end
    end

    assign read_word           = out_of_range ? 32'd0 : mem[cap_index];
    assign data_mem_data_inout = drive_read ? read_word : 32'bz;

    assign data_mem.ready = ready;
    assign data_mem.err   = err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Self-checking bench for data_mem_responder. Two instances are
//             exercised: one with two wait states and one with none. Expected
//             values come from a word-level memory model (associative array)
//             and the latency rule (ready WAIT_STATES+1 cycles after accept).
//  Options  : honours DATA_MEM_BOUNDS_CHECK_EN for expected err/read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int WS_A       = 2;
    localparam int WS_B       = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a;
    logic        req_b;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr;
    logic        drv_en_a;
    logic        drv_en_b;
    logic [31:0] drv_val_a;
    logic [31:0] drv_val_b;
    wire  [31:0] bus_a;
    wire  [31:0] bus_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Word-level reference memories; a missing key means contents unknown.
    logic [31:0] model_a [int];
    logic [31:0] model_b [int];

    // Clock generation.
    always #5 clk = ~clk;

    data_mem_responder_if if_a ();
    data_mem_responder_if if_b ();

    assign if_a.req  = req_a;
    assign if_a.we   = s_we;
    assign if_a.be   = s_be;
    assign if_a.addr = s_addr;
    assign if_b.req  = req_b;
    assign if_b.we   = s_we;
    assign if_b.be   = s_be;
    assign if_b.addr = s_addr;

    // CPU side of each bus; driving 0 lets a stray DUT driver show up.
    assign bus_a = drv_en_a ? drv_val_a : 32'bz;
    assign bus_b = drv_en_b ? drv_val_b : 32'bz;

    data_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(WS_A)) u_dut_a (
        .clock_in            (clk),
        .reset_in            (rst),
        .data_mem            (if_a),
        .data_mem_data_inout (bus_a)
    );

    data_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(WS_B)) u_dut_b (
        .clock_in            (clk),
        .reset_in            (rst),
        .data_mem            (if_b),
        .data_mem_data_inout (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_oob(input logic [31:0] a);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
        return (a >> (DEPTH_LOG2 + 2)) != 32'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_index(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << DEPTH_LOG2));
    endfunction

    function automatic void model_write(input bit sel, input int idx, input logic [3:0] be,
                                        input logic [31:0] d);
        logic [31:0] w;
        bit          known;
        known = sel ? model_b.exists(idx) : model_a.exists(idx);
        if (be == 4'hF) begin
            w = d;
        end else if (!known) begin
            return;
        end else begin
            w = sel ? model_b[idx] : model_a[idx];
            for (int i = 0; i < 4; i++) begin
                if (be[i]) w[8*i +: 8] = d[8*i +: 8];
            end
        end
        if (sel) model_b[idx] = w;
        else     model_a[idx] = w;
    endfunction

    function automatic logic obs_ready(input bit sel);
        return sel ? if_b.ready : if_a.ready;
    endfunction

    function automatic logic obs_err(input bit sel);
        return sel ? if_b.err : if_a.err;
    endfunction

    function automatic logic [31:0] obs_bus(input bit sel);
        return sel ? bus_b : bus_a;
    endfunction

    task automatic set_req(input bit sel, input logic v);
        if (sel) req_b = v;
        else     req_a = v;
    endtask

    task automatic set_bus(input bit sel, input logic en, input logic [31:0] v);
        if (sel) begin
            drv_en_b  = en;
            drv_val_b = v;
        end else begin
            drv_en_a  = en;
            drv_val_a = v;
        end
    endtask

    // One transaction; entered and left 1 ns after a rising edge with the DUT idle.
    task automatic txn(input bit sel, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int          ws;
        bit          oob;
        int          idx;
        bit          known;
        logic [31:0] exp_rd;
        ws  = sel ? WS_B : WS_A;
        oob = model_oob(addr);
        idx = model_index(addr);
        if (oob) begin
            known  = 1'b1;
            exp_rd = 32'd0;
        end else begin
            known  = sel ? model_b.exists(idx) : model_a.exists(idx);
            exp_rd = known ? (sel ? model_b[idx] : model_a[idx]) : 32'd0;
        end

        s_we   = we;
        s_be   = be;
        s_addr = addr;
        set_req(sel, 1'b1);
        set_bus(sel, 1'b1, we ? wdata : 32'd0);
        @(negedge clk);
        check({tag, "/idle_ready"}, 32'(obs_ready(sel)), 32'd0);
        if (!we) check({tag, "/idle_hiz"}, obs_bus(sel), 32'd0);
        @(posedge clk);
        #1;

        // Wait cycles: request held high and all other inputs scrambled.
        for (int i = 0; i < ws; i++) begin
            s_we   = 1'($urandom_range(0, 1));
            s_be   = 4'($urandom);
            s_addr = $urandom;
            set_bus(sel, 1'b1, $urandom);
            @(negedge clk);
            check({tag, "/wait_ready"}, 32'(obs_ready(sel)), 32'd0);
            check({tag, "/wait_err"}, 32'(obs_err(sel)), 32'd0);
            @(posedge clk);
            #1;
        end

        // Response cycle.
        s_we   = 1'($urandom_range(0, 1));
        s_be   = 4'($urandom);
        s_addr = $urandom;
        if (we) set_bus(sel, 1'b1, $urandom);
        else    set_bus(sel, 1'b0, 32'd0);
        @(negedge clk);
        check({tag, "/resp_ready"}, 32'(obs_ready(sel)), 32'd1);
        check({tag, "/resp_err"}, 32'(obs_err(sel)), 32'(oob));
        if (!we && known) check({tag, "/resp_data"}, obs_bus(sel), exp_rd);
        @(posedge clk);
        #1;
        if (we && !oob) model_write(sel, idx, be, wdata);
        set_req(sel, 1'b0);
        set_bus(sel, 1'b1, 32'd0);
    endtask

    // Global time limit so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    logic [31:0] pool [8];

    initial begin
        rst       = 1'b1;
        req_a     = 1'b0;
        req_b     = 1'b0;
        s_we      = 1'b0;
        s_be      = 4'd0;
        s_addr    = 32'd0;
        drv_en_a  = 1'b1;
        drv_en_b  = 1'b1;
        drv_val_a = 32'd0;
        drv_val_b = 32'd0;

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset/ready_a", 32'(if_a.ready), 32'd0);
        check("reset/err_a", 32'(if_a.err), 32'd0);
        check("reset/hiz_a", bus_a, 32'd0);
        check("reset/ready_b", 32'(if_b.ready), 32'd0);
        check("reset/err_b", 32'(if_b.err), 32'd0);
        check("reset/hiz_b", bus_b, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full write then read back, two wait states.
        txn(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, "w10");
        txn(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'd0, "r10");

        // Partial byte-enable merge.
        txn(1'b0, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, "w20");
        txn(1'b0, 1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, "w20_be");
        txn(1'b0, 1'b0, 4'hF, 32'h0000_0020, 32'd0, "r20");
        check("r20_merge_rule", model_a[8], 32'h11BB_33DD);

        // Empty byte mask completes but changes nothing.
        txn(1'b0, 1'b1, 4'b0000, 32'h0000_0020, 32'hFFFF_FFFF, "w20_be0");
        txn(1'b0, 1'b0, 4'hF, 32'h0000_0020, 32'd0, "r20_be0");

        // Zero wait states, requests back to back.
        txn(1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_F00D, "b_w100");
        txn(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'd0, "b_r100");
        txn(1'b1, 1'b1, 4'b1000, 32'h0000_0101, 32'h5A00_0000, "b_w100_be");
        txn(1'b1, 1'b0, 4'hF, 32'h0000_0103, 32'd0, "b_r100b");

        // Reset one cycle into WAIT of a write aborts it.
        txn(1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'h0BAD_F00D, "pre40");
        s_we   = 1'b1;
        s_be   = 4'hF;
        s_addr = 32'h0000_0040;
        req_a  = 1'b1;
        set_bus(1'b0, 1'b1, 32'h5555_5555);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        req_a = 1'b0;
        set_bus(1'b0, 1'b1, 32'd0);
        @(negedge clk);
        check("rst40/ready", 32'(if_a.ready), 32'd0);
        check("rst40/hiz", bus_a, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst40/no_ready", 32'(if_a.ready), 32'd0);
            @(posedge clk);
            #1;
        end
        txn(1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'd0, "r40");

        // Addresses beyond the array.
        txn(1'b0, 1'b1, 4'hF, 32'h0000_0000, 32'h1357_9BDF, "w0");
        txn(1'b0, 1'b0, 4'hF, 32'h0001_0000, 32'd0, "r_oob");
        txn(1'b0, 1'b1, 4'hF, 32'h0001_0010, 32'h7777_7777, "w_oob");
        txn(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'd0, "r10_after_oob");

        // Randomized traffic over a small known address pool on both instances.
        for (int k = 0; k < 8; k++) begin
            pool[k] = {20'd0, 10'($urandom), 2'b00};
            txn(1'b0, 1'b1, 4'hF, pool[k], $urandom, "rnd_init_a");
            txn(1'b1, 1'b1, 4'hF, pool[k], $urandom, "rnd_init_b");
        end
        for (int k = 0; k < 60; k++) begin
            bit          sel;
            logic [31:0] a;
            sel = 1'($urandom_range(0, 1));
            a   = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom << (DEPTH_LOG2 + 2));
            txn(sel, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
